// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matrix-multiply sequencer.
//   state_t   : sequencer states (IDLE, RUN, DRAIN, DONE)
//   idx_w()   : index width for a given matrix dimension
//   N_MAX, MAC_LAT_MAX : upper bounds of the N / MAC_LAT parameters
//   wr_tok_t  : result-write token {we, row, col} carried by the delay line,
//               sized for N_MAX so one type serves every legal N.
package matmul_pkg;

  localparam int N_MAX       = 16;
  localparam int MAC_LAT_MAX = 8;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  localparam int IW_MAX = idx_w(N_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [IW_MAX-1:0] row;
    logic [IW_MAX-1:0] col;
  } wr_tok_t;

endpackage

// File: rtl/matmul_dly.sv
// matmul_dly: LAT-stage shift register for the result-write token.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  synchronous active-low reset; clears every stage
//   i_tok in  token entering the line this cycle
//   o_tok out token that entered LAT cycles ago
module matmul_dly
  import matmul_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  wr_tok_t i_tok,
  output wr_tok_t o_tok
);

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    wr_tok_t r_q;
    wr_tok_t w_d;

    if (gi == 0) begin : g_head
      assign w_d = i_tok;
    end else begin : g_tail
      assign w_d = g_stage[gi-1].r_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q <= '0;
      end else begin
        r_q <= w_d;
      end
    end
  end

  assign o_tok = g_stage[LAT-1].r_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencer for C = A x B on a single shared MAC.
// Issues one (i,j,k) term per cycle (k innermost, then j, then i), drives
// the A/B read addresses and MAC clear/enable, and emits the C write strobe
// MAC_LAT cycles after the k==N-1 term of each dot product.
// Optional feature macro: MATMUL_STALL_EN adds the 'stall' input (RUN only).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a multiply (sampled in IDLE only)
//   stall           (MATMUL_STALL_EN) hold issue for this cycle
//   busy, done      status; done is a one-cycle completion pulse
//   a_row/a_col     A read address (i, k)
//   b_row/b_col     B read address (k, j)
//   mac_en/mac_clr  MAC consume / load-instead-of-accumulate
//   c_we/c_row/c_col  C write strobe and address
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int  N       = 2,
  parameter int  MAC_LAT = 2,
  localparam int IW      = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef MATMUL_STALL_EN
  input  logic          stall,
`endif
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] a_row,
  output logic [IW-1:0] a_col,
  output logic [IW-1:0] b_row,
  output logic [IW-1:0] b_col,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          c_we,
  output logic [IW-1:0] c_row,
  output logic [IW-1:0] c_col
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam int            CW   = $clog2(MAC_LAT_MAX);

  state_t        r_state, w_state_next;
  logic [IW-1:0] r_i, r_j, r_k;
  logic [IW-1:0] w_i_next, w_j_next, w_k_next;
  logic          r_mac_en, r_mac_clr;
  logic          w_mac_en_next, w_mac_clr_next;
  logic [CW-1:0] r_drain, w_drain_next;
  logic          w_stall, w_last, w_busy, w_done;
  wr_tok_t       w_tok_in, w_tok_out;
  logic          w_unused_tok;

`ifdef MATMUL_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // The registered indices always show a term that has already been issued,
  // so seeing the last term here means the issue phase is complete.
  assign w_last = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_drain   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_i       <= w_i_next;
      r_j       <= w_j_next;
      r_k       <= w_k_next;
      r_mac_en  <= w_mac_en_next;
      r_mac_clr <= w_mac_clr_next;
      r_drain   <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_i_next       = r_i;
    w_j_next       = r_j;
    w_k_next       = r_k;
    w_mac_en_next  = 1'b0;
    w_mac_clr_next = 1'b0;
    w_drain_next   = r_drain;
    w_busy         = 1'b1;
    w_done         = 1'b0;

    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state_next   = RUN;
          w_i_next       = '0;
          w_j_next       = '0;
          w_k_next       = '0;
          w_mac_en_next  = 1'b1;
          w_mac_clr_next = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          // Last write token is in flight; count MAC_LAT cycles so DRAIN
          // ends in the same cycle as the final c_we.
          w_state_next = DRAIN;
          w_drain_next = CW'(MAC_LAT - 1);
        end else if (!w_stall) begin
          w_mac_en_next = 1'b1;
          if (r_k != LAST) begin
            w_k_next = r_k + 1'b1;
          end else begin
            w_k_next = '0;
            if (r_j != LAST) begin
              w_j_next = r_j + 1'b1;
            end else begin
              w_j_next = '0;
              w_i_next = r_i + 1'b1;
            end
          end
          w_mac_clr_next = (w_k_next == '0);
        end
      end
      DRAIN: begin
        if (r_drain == '0) begin
          w_state_next = DONE;
        end else begin
          w_drain_next = r_drain - 1'b1;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // A token is launched alongside the k==N-1 term, so it leaves the delay
  // line exactly MAC_LAT cycles after that term's mac_en.
  always_comb begin
    w_tok_in     = '0;
    w_tok_in.we  = r_mac_en && (r_k == LAST);
    w_tok_in.row = IW_MAX'(r_i);
    w_tok_in.col = IW_MAX'(r_j);
  end

  matmul_dly #(
    .LAT (MAC_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tok (w_tok_in),
    .o_tok (w_tok_out)
  );

  // Upper token bits are only live for the largest N.
  assign w_unused_tok = ^{w_tok_out.row, w_tok_out.col};

  assign busy    = w_busy;
  assign done    = w_done;
  assign a_row   = r_i;
  assign a_col   = r_k;
  assign b_row   = r_k;
  assign b_col   = r_j;
  assign mac_en  = r_mac_en;
  assign mac_clr = r_mac_clr;
  assign c_we    = w_tok_out.we;
  assign c_row   = w_tok_out.row[IW-1:0];
  assign c_col   = w_tok_out.col[IW-1:0];

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Testbench for matmul_seq_ctrl: two instances (N=2/MAC_LAT=2 and
// N=3/MAC_LAT=1) share start/rst_n/stall. Each instance has a term-count
// reference model that queues expected issue/write/done events and a
// monitor that pops and compares them as the DUT presents outputs.
module tb_matmul_seq_ctrl;

  typedef struct {
    int cyc;
    int i;
    int j;
    int k;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   end_phase = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int inst, input string nm, input int lbl,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d, cycle %0d): got %0d, expected %0d", nm, inst, lbl, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rn, input logic sl);
    @(negedge clk);
    #1;
    start = st;
    rst_n = rn;
    stall = sl;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic rnd_stall();
`ifdef MATMUL_STALL_EN
    return ($urandom_range(0, 3) == 0);
`else
    return 1'b0;
`endif
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int NN = (gi == 0) ? 2 : 3;
    localparam int LL = (gi == 0) ? 2 : 1;
    localparam int IW = $clog2(NN);
    localparam int NT = NN * NN * NN;

    logic          busy, done, mac_en, mac_clr, c_we;
    logic [IW-1:0] a_row, a_col, b_row, b_col, c_row, c_col;

    ev_t iq[$];
    ev_t wq[$];
    int  dq[$];
    ev_t tq[$];
    int  tdq[$];
    ev_t e;
    int  d;
    int  lbl;
    int  idle_from = 0;
    int  busy_lo = 0;
    int  zero_lbl = -1;
    int  t = 0;
    bit  run = 1'b0;
    bit  issue;

    matmul_seq_ctrl #(
      .N       (NN),
      .MAC_LAT (LL)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
`ifdef MATMUL_STALL_EN
      .stall   (stall),
`endif
      .busy    (busy),
      .done    (done),
      .a_row   (a_row),
      .a_col   (a_col),
      .b_row   (b_row),
      .b_col   (b_col),
      .mac_en  (mac_en),
      .mac_clr (mac_clr),
      .c_we    (c_we),
      .c_row   (c_row),
      .c_col   (c_col)
    );

    always @(negedge clk) begin
      lbl = cyc;
      // ---------------- monitor ----------------
      if (lbl >= 1) begin
        if (lbl == zero_lbl)
          chk(gi, "reset_zero", lbl,
              32'({busy, done, mac_en, mac_clr, c_we, a_row, a_col, b_row, b_col, c_row, c_col}), 0);
        chk(gi, "busy", lbl, 32'(busy), 32'(lbl >= busy_lo && lbl < idle_from));

        while (iq.size() > 0 && iq[0].cyc < lbl) begin
          chk(gi, "issue_missed", lbl, iq[0].cyc, lbl);
          e = iq.pop_front();
        end
        if (mac_en === 1'b1) begin
          chk(gi, "issue_expected", lbl, 32'(iq.size() > 0), 1);
          if (iq.size() > 0) begin
            e = iq.pop_front();
            chk(gi, "issue_cycle", lbl, lbl, e.cyc);
            chk(gi, "issue_addr{ar,ac,br,bc}", lbl, 32'({a_row, a_col, b_row, b_col}),
                32'({IW'(e.i), IW'(e.k), IW'(e.k), IW'(e.j)}));
            chk(gi, "mac_clr", lbl, 32'(mac_clr), 32'(e.k == 0));
          end
        end else begin
          chk(gi, "clr_without_en", lbl, 32'(mac_clr), 0);
        end

        while (wq.size() > 0 && wq[0].cyc < lbl) begin
          chk(gi, "write_missed", lbl, wq[0].cyc, lbl);
          e = wq.pop_front();
        end
        if (c_we === 1'b1) begin
          chk(gi, "write_expected", lbl, 32'(wq.size() > 0), 1);
          if (wq.size() > 0) begin
            e = wq.pop_front();
            chk(gi, "write_cycle", lbl, lbl, e.cyc);
            chk(gi, "write_addr{row,col}", lbl, 32'({c_row, c_col}),
                32'({IW'(e.i), IW'(e.j)}));
          end
        end

        while (dq.size() > 0 && dq[0] < lbl) begin
          chk(gi, "done_missed", lbl, dq[0], lbl);
          d = dq.pop_front();
        end
        if (done === 1'b1) begin
          chk(gi, "done_expected", lbl, 32'(dq.size() > 0), 1);
          if (dq.size() > 0) begin
            d = dq.pop_front();
            chk(gi, "done_cycle", lbl, lbl, d);
          end
        end
      end

      #2;
      // ---------------- reference model ----------------
      // Inputs driven during label lbl are sampled at the edge ending it;
      // their effect is visible from label lbl+1.
      if (rst_n !== 1'b1) begin
        tq = {};
        foreach (iq[x]) if (iq[x].cyc <= lbl) tq.push_back(iq[x]);
        iq = tq;
        tq = {};
        foreach (wq[x]) if (wq[x].cyc <= lbl) tq.push_back(wq[x]);
        wq = tq;
        tdq = {};
        foreach (dq[x]) if (dq[x] <= lbl) tdq.push_back(dq[x]);
        dq = tdq;
        run       = 1'b0;
        idle_from = lbl + 1;
        zero_lbl  = lbl + 1;
      end else begin
        issue = 1'b0;
        if (!run) begin
          if (start === 1'b1 && lbl >= idle_from) begin
            run       = 1'b1;
            t         = 0;
            busy_lo   = lbl + 1;
            idle_from = 32'h3fff_ffff;
            issue     = 1'b1;
          end
        end else if (stall !== 1'b1) begin
          issue = 1'b1;
        end
        if (issue) begin
          e.cyc = lbl + 1;
          e.i   = t / (NN * NN);
          e.j   = (t / NN) % NN;
          e.k   = t % NN;
          iq.push_back(e);
          if (e.k == NN - 1) begin
            e.cyc = lbl + 1 + LL;
            wq.push_back(e);
          end
          t++;
          if (t == NT) begin
            dq.push_back(lbl + 2 + LL);
            idle_from = lbl + 3 + LL;
            run       = 1'b0;
          end
        end
      end
    end

    initial begin
      wait (end_phase);
      chk(gi, "issue_queue_left", cyc, 32'(iq.size()), 0);
      chk(gi, "write_queue_left", cyc, 32'(wq.size()), 0);
      chk(gi, "done_queue_left", cyc, 32'(dq.size()), 0);
    end
  end

  initial begin
    int gap, hold, w;
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0);
    idle(3);

    // Single start pulse: full run on both sizes.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(35);

    // Start held high: back-to-back runs without overlap.
    drive(1'b1, 1'b1, 1'b0);
    idle(15);
    drive(1'b0, 1'b1, 1'b0);
    idle(40);

    // Reset in cycle 5 of a run, then a fresh run.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(3);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(35);

    // Start pulse landing on the DONE cycle of the N=2 instance.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(9);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(35);

`ifdef MATMUL_STALL_EN
    // Stall in cycles 3..4 of a run.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 1'b1);
    idle(1);
    drive(1'b0, 1'b1, 1'b0);
    idle(40);
`endif

    // Randomized runs, random start length, occasional mid-run reset.
    for (int it = 0; it < 16; it++) begin
      gap = $urandom_range(0, 4);
      idle(gap);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) drive(1'b1, 1'b1, rnd_stall());
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(1, 25);
        for (int c = 0; c < w; c++) drive(1'b0, 1'b1, rnd_stall());
        drive(1'b0, 1'b0, 1'b0);
      end
      for (int c = 0; c < 70; c++) drive(1'b0, 1'b1, rnd_stall());
    end

    drive(1'b0, 1'b1, 1'b0);
    idle(60);
    end_phase = 1'b1;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for an N x N matrix multiply, C = A x B, executed on one shared multiply-accumulate unit built from reversible HNG-based adders.
- Issues one (i, j, k) term per cycle and drives the A/B operand read addresses and the MAC clear/enable controls.
- Delays each result write strobe by the MAC pipeline latency.
- Sits between the top-level start/done handshake and the reversible MAC datapath plus the A/B/C operand memories.

Parameters:
- N, 2, matrix dimension; legal range 2..16.
- MAC_LAT, 2, cycles from the last mac_en of a dot product until the MAC result is valid; legal range 1..8.
- IW, $clog2(N), index width; localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new multiply; sampled only in IDLE.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking completion.
- a_row  output  IW  A read row index (i).
- a_col  output  IW  A read column index (k).
- b_row  output  IW  B read row index (k).
- b_col  output  IW  B read column index (j).
- mac_en  output  1  MAC consumes the current operand pair this cycle.
- mac_clr  output  1  with mac_en: load the product, do not accumulate (k==0).
- c_we  output  1  write the MAC result to C.
- c_row  output  IW  C write row.
- c_col  output  IW  C write column.

Behaviour:
- Reset: clk and rst_n as stated above. With rst_n low at a rising edge, state returns to IDLE, all indices go to 0, and every output, including the delay pipeline, goes to 0. Reset mid-operation aborts the run; no c_we and no done follow it.
- States:
  - IDLE: busy=0. start=1 -> RUN, indices = 0.
  - RUN: busy=1. One term issued per cycle with mac_en=1; mac_clr=(k==0).
  - DRAIN: busy=1, mac_en=0. Waits for the delay pipeline to empty.
  - DONE: busy=1, done=1 for one cycle, then -> IDLE.
- Loop order: k innermost, then j, then i. Each counter wraps N-1 -> 0 and carries to the next. The last term (i=j=k=N-1) moves RUN -> DRAIN.
- Operand addresses: a_row=i, a_col=k, b_row=k, b_col=j, all registered and aligned with mac_en.
- Result write: when k==N-1 is issued, a write token {1, i, j} enters a MAC_LAT-deep delay line. c_we/c_row/c_col are that token after MAC_LAT cycles, so each write is MAC_LAT cycles after the term's mac_en.
- DRAIN lasts MAC_LAT cycles after the last issue; it ends in the cycle of the final c_we.
- Latency: if start is sampled at edge 0:
  - issue cycles are 1..N^3;
  - the final c_we is in cycle N^3+MAC_LAT;
  - done is in cycle N^3+MAC_LAT+1;
  - IDLE from the next edge.
- start while busy=1, including the DONE cycle, is ignored; there is no queueing.
- start held high continuously: a new run begins on the first edge where the block is in IDLE.
- Outside RUN, mac_en and mac_clr are 0. Index outputs hold their last value in DRAIN and DONE.

Optional Feature:
- Macro MATMUL_STALL_EN.
- Defined: adds input port stall (1 bit), honoured in RUN only. While stall=1, the i/j/k counters hold, mac_en=0 and mac_clr=0, and no token enters the delay line. The delay line keeps shifting so writes already in flight complete on time. stall is ignored in IDLE, DRAIN and DONE.
- Undefined: no stall port; RUN always issues one term per cycle.

Decomposition:
- Shared package matmul_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - function idx_w(N) returning $clog2(N);
  - constants N_MAX=16 and MAC_LAT_MAX=8;
  - the write-token struct {we, row, col}.
- Natural sub-module: matmul_dly, a parameterised MAC_LAT-stage shift register carrying the write token, cleared by rst_n.

Test Plan:
1. N=2, MAC_LAT=2; start pulse at edge 0:
   - (i,j,k) sequence over cycles 1..8 is 000,001,010,011,100,101,110,111;
   - mac_clr in cycles 1,3,5,7;
   - c_we in cycles 4,6,8,10 with (row,col)=00,01,10,11;
   - done only in cycle 11; busy in cycles 1..11.
2. start held high through cycles 0..15 -> second run issues its first term in cycle 13; no overlap with run 1.
3. rst_n low in cycle 5 of a run -> from the next edge all outputs are 0 and state is IDLE; no c_we or done afterwards; a fresh start completes normally.
4. N=3, MAC_LAT=1 -> 27 issue cycles; 9 c_we pulses, one per (i,j) in row-major order, each 1 cycle after its k=2 term; done in cycle 29.
5. MATMUL_STALL_EN, N=2, MAC_LAT=2, stall=1 in cycles 3..4:
   - indices hold at 010 during the stall, mac_en=0;
   - the write for (0,0) still appears in cycle 4;
   - done moves to cycle 13.
6. start pulse in the DONE cycle -> ignored; busy=0 the following cycle; no second run.
